umi_mem_responder: RTL and testbench

- UMI responder endpoint that sits on one output port of umi_switch and completes single-word read/write requests against a local register array.
- Returns read and write responses on a separate UMI response channel; posted writes get no response.
- Gives switch benches and small SoC tiles a self-checking memory target.

---
 rtl/umi_mem_responder.sv | 193 +++++++++++++++++++
 tb/tb_umi_mem_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/umi_mem_responder.sv
// umi_mem_responder: single-word UMI memory target for one switch output port.
// Completes READ / WRITE / POSTED requests against a local DEPTH x DW register
// array and returns responses on a separate UMI channel. One request is handled
// at a time: a responded request holds the input off until the response is taken.
//
// Optional build macro: UMI_RESP_ERR_EN
//   defined   - illegal READ/WRITE (or unsupported opcode) gets an error response
//               (err = DEVERR); illegal POSTED is dropped.
//   undefined - every illegal request is accepted and silently discarded.
module umi_mem_responder #(
    parameter int DW    = 256,
    parameter int AW    = 64,
    parameter int CW    = 32,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          umi_in_valid,
    input  logic [CW-1:0] umi_in_cmd,
    input  logic [AW-1:0] umi_in_dstaddr,
    input  logic [AW-1:0] umi_in_srcaddr,
    input  logic [DW-1:0] umi_in_data,
    output logic          umi_in_ready,
    output logic          umi_out_valid,
    output logic [CW-1:0] umi_out_cmd,
    output logic [AW-1:0] umi_out_dstaddr,
    output logic [AW-1:0] umi_out_srcaddr,
    output logic [DW-1:0] umi_out_data,
    input  logic          umi_out_ready
);

    localparam int NB = DW / 8;            // bytes per word
    localparam int OB = $clog2(NB);        // byte-offset bits
    localparam int IW = $clog2(DEPTH);     // word-index bits

    localparam logic [4:0] REQ_READ   = 5'h01;
    localparam logic [4:0] REQ_WRITE  = 5'h03;
    localparam logic [4:0] REQ_POSTED = 5'h05;
    localparam logic [4:0] RESP_READ  = 5'h02;
    localparam logic [4:0] RESP_WRITE = 5'h04;

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t r_state, w_next;

    logic [DW-1:0] r_mem [DEPTH];

    // request field decode
    logic [4:0]    w_op;
    logic [2:0]    w_size;
    logic [7:0]    w_len;
    logic [OB-1:0] w_offset;
    logic [IW-1:0] w_index;
    logic [OB:0]   w_bytes;
    logic [OB:0]   w_bytes_m1;
    logic          w_op_ok;
    logic          w_legal;

    assign w_op       = umi_in_cmd[4:0];
    assign w_size     = umi_in_cmd[7:5];
    assign w_len      = umi_in_cmd[15:8];
    assign w_offset   = umi_in_dstaddr[OB-1:0];
    assign w_index    = umi_in_dstaddr[OB+:IW];
    assign w_bytes    = (OB+1)'(1) << w_size;
    assign w_bytes_m1 = w_bytes - 1'b1;
    assign w_op_ok    = (w_op == REQ_READ) || (w_op == REQ_WRITE) || (w_op == REQ_POSTED);
    assign w_legal    = w_op_ok && (w_len == 8'd0) && (int'(w_size) <= OB) &&
                        ((w_offset & w_bytes_m1[OB-1:0]) == '0);

    // lane enables, write data aligned to lanes, read data aligned to bit 0
    logic [NB-1:0] w_be;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rshift;
    logic [DW-1:0] w_rdata;

    assign w_wdata  = umi_in_data << {w_offset, 3'b000};
    assign w_rshift = r_mem[w_index] >> {w_offset, 3'b000};

    // Byte-lane window [offset, offset+bytes) and zero-extended read data
    always_comb begin
        w_be    = '0;
        w_rdata = '0;
        for (int b = 0; b < NB; b++) begin
            w_be[b] = (b >= int'(w_offset)) && (b < int'(w_offset) + int'(w_bytes));
            if (b < int'(w_bytes)) begin
                w_rdata[b*8+:8] = w_rshift[b*8+:8];
            end
        end
    end

    // FSM next-state and request-handling decisions
    logic          w_ready;
    logic          w_mem_we;
    logic          w_load;
    logic [4:0]    w_resp_op;
    logic [1:0]    w_resp_err;
    logic [DW-1:0] w_resp_data;
    logic [CW-1:0] w_resp_cmd;

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        w_next      = r_state;
        w_ready     = 1'b0;
        w_mem_we    = 1'b0;
        w_load      = 1'b0;
        w_resp_op   = RESP_WRITE;
        w_resp_err  = 2'b00;
        w_resp_data = '0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (umi_in_valid) begin
                    if (w_legal) begin
                        if (w_op == REQ_READ) begin
                            w_load      = 1'b1;
                            w_resp_op   = RESP_READ;
                            w_resp_data = w_rdata;
                            w_next      = S_RESP;
                        end else begin
                            w_mem_we = 1'b1;
                            if (w_op == REQ_WRITE) begin
                                w_load = 1'b1;
                                w_next = S_RESP;
                            end
                        end
                    end
`ifdef UMI_RESP_ERR_EN
                    else if (w_op != REQ_POSTED) begin
                        w_load     = 1'b1;
                        w_resp_op  = (w_op == REQ_READ) ? RESP_READ : RESP_WRITE;
                        w_resp_err = 2'b10;
                        w_next     = S_RESP;
                    end
`endif
                end
            end
            S_RESP: begin
                if (umi_out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // response command: request cmd with opcode and err replaced
    always_comb begin
        w_resp_cmd         = umi_in_cmd;
        w_resp_cmd[4:0]    = w_resp_op;
        w_resp_cmd[26:25]  = w_resp_err;
    end

    assign umi_in_ready  = w_ready & ~reset;
    assign umi_out_valid = (r_state == S_RESP);

    // State register
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Response register: captured in the accept cycle, held stable through RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            umi_out_cmd     <= '0;
            umi_out_dstaddr <= '0;
            umi_out_srcaddr <= '0;
            umi_out_data    <= '0;
        end else if (w_load) begin
            umi_out_cmd     <= w_resp_cmd;
            umi_out_dstaddr <= umi_in_srcaddr;
            umi_out_srcaddr <= umi_in_dstaddr;
            umi_out_data    <= w_resp_data;
        end
    end

    // Memory array byte-lane write
    // NOTE: the array has no reset; contents deliberately survive a reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) begin
                    r_mem[w_index][b*8+:8] <= w_wdata[b*8+:8];
                end
            end
        end
    end

endmodule

// File: tb/tb_umi_mem_responder.sv
// Directed self-checking bench for umi_mem_responder (default parameters).
module tb_umi_mem_responder;

    localparam int DW    = 256;
    localparam int AW    = 64;
    localparam int CW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [CW-1:0] in_cmd;
    logic [AW-1:0] in_dst;
    logic [AW-1:0] in_src;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [CW-1:0] out_cmd;
    logic [AW-1:0] out_dst;
    logic [AW-1:0] out_src;
    logic [DW-1:0] out_data;
    logic          out_ready;

    int total = 0;
    int bad   = 0;

    umi_mem_responder #(.DW(DW), .AW(AW), .CW(CW), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .umi_in_valid    (in_valid),
        .umi_in_cmd      (in_cmd),
        .umi_in_dstaddr  (in_dst),
        .umi_in_srcaddr  (in_src),
        .umi_in_data     (in_data),
        .umi_in_ready    (in_ready),
        .umi_out_valid   (out_valid),
        .umi_out_cmd     (out_cmd),
        .umi_out_dstaddr (out_dst),
        .umi_out_srcaddr (out_src),
        .umi_out_data    (out_data),
        .umi_out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] mk_cmd(input logic [4:0] op, input logic [2:0] size,
                                              input logic [7:0] len);
        return {16'h0000, len, size, op};
    endfunction

    // Present one request at a negedge, wait (bounded) for ready, complete it on the
    // next posedge; returns 1 time unit after the accepting edge.
    task automatic do_req(input logic [CW-1:0] cmd, input logic [AW-1:0] dst,
                          input logic [AW-1:0] src, input logic [DW-1:0] data);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_cmd   = cmd;
        in_dst   = dst;
        in_src   = src;
        in_data  = data;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Take the pending response now and check the responder is back in IDLE.
    task automatic take_resp();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("resp_done_valid", out_valid, 1'b0);
        check("resp_done_ready", in_ready, 1'b1);
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] addr,
                              input logic [DW-1:0] exp);
        do_req(mk_cmd(5'h01, 3'd3, 8'd0), addr, 64'hB000, '0);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_cmd"}, out_cmd, mk_cmd(5'h02, 3'd3, 8'd0));
        check({tag, "_data"}, out_data, exp);
        take_resp();
    endtask

    logic [CW-1:0] held_cmd;
    logic [DW-1:0] held_data;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_cmd    = '0;
        in_dst    = '0;
        in_src    = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // reset state
        #12;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_out_valid", out_valid, 1'b0);
        check("idle_out_cmd", out_cmd, '0);
        check("idle_out_data", out_data, '0);

        // write then read
        do_req(mk_cmd(5'h03, 3'd3, 8'd0), 64'h10, 64'hA000, 256'h1122334455667788);
        check("wr_valid", out_valid, 1'b1);
        check("wr_cmd", out_cmd, mk_cmd(5'h04, 3'd3, 8'd0));
        check("wr_dst", out_dst, 64'hA000);
        check("wr_src", out_src, 64'h10);
        check("wr_data", out_data, '0);
        check("wr_in_ready", in_ready, 1'b0);
        take_resp();
        read_check("rd1", 64'h10, 256'h1122334455667788);

        // byte-lane merge
        do_req(mk_cmd(5'h03, 3'd0, 8'd0), 64'h13, 64'hA000, 256'hEE);
        check("merge_wr_valid", out_valid, 1'b1);
        take_resp();
        read_check("merge_rd", 64'h10, 256'h11223344EE667788);

        // three back-to-back posted writes: ready stays high, no response
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_cmd   = mk_cmd(5'h05, 3'd3, 8'd0);
            in_dst   = AW'(i * (DW / 8));
            in_src   = 64'hC000;
            in_data  = DW'(i + 1);
            check("posted_ready", in_ready, 1'b1);
            check("posted_no_valid", out_valid, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("posted_end_no_valid", out_valid, 1'b0);
        read_check("posted_rd0", 64'h00, 256'h1);
        read_check("posted_rd1", 64'h20, 256'h2);
        read_check("posted_rd2", 64'h40, 256'h3);

        // backpressure: response held stable for 5 cycles
        do_req(mk_cmd(5'h01, 3'd3, 8'd0), 64'h10, 64'hD000, '0);
        held_cmd  = mk_cmd(5'h02, 3'd3, 8'd0);
        held_data = 256'h11223344EE667788;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_cmd", out_cmd, held_cmd);
            check("bp_dst", out_dst, 64'hD000);
            check("bp_data", out_data, held_data);
            @(posedge clk);
            #1;
        end
        take_resp();

        // wrap: index DEPTH aliases index 0
        do_req(mk_cmd(5'h05, 3'd3, 8'd0), AW'(DEPTH * DW / 8), 64'hC000, 256'hABCD);
        check("wrap_no_valid", out_valid, 1'b0);
        read_check("wrap_rd", 64'h00, 256'hABCD);

        // illegal read (len=1) and illegal misaligned write
        do_req(mk_cmd(5'h01, 3'd3, 8'd1), 64'h00, 64'hE000, '0);
`ifdef UMI_RESP_ERR_EN
        check("ill_rd_valid", out_valid, 1'b1);
        check("ill_rd_cmd", out_cmd, mk_cmd(5'h02, 3'd3, 8'd1) | 32'h0400_0000);
        check("ill_rd_data", out_data, '0);
        take_resp();
`else
        check("ill_rd_no_valid", out_valid, 1'b0);
        check("ill_rd_ready", in_ready, 1'b1);
`endif
        do_req(mk_cmd(5'h03, 3'd3, 8'd0), 64'h04, 64'hE000, 256'hDEAD);
`ifdef UMI_RESP_ERR_EN
        check("ill_wr_valid", out_valid, 1'b1);
        check("ill_wr_cmd", out_cmd, mk_cmd(5'h04, 3'd3, 8'd0) | 32'h0400_0000);
        take_resp();
`else
        check("ill_wr_no_valid", out_valid, 1'b0);
`endif
        read_check("ill_mem_kept", 64'h00, 256'hABCD);

        // reset while a response is pending
        do_req(mk_cmd(5'h01, 3'd3, 8'd0), 64'h10, 64'hF000, '0);
        check("rstr_valid", out_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("rstr_async_drop", out_valid, 1'b0);
        check("rstr_ready_low", in_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstr_no_replay", out_valid, 1'b0);
        end
        out_ready = 1'b0;
        read_check("rstr_mem_kept", 64'h10, 256'h11223344EE667788);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
